// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipelined RISC-V core.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // ID/EX stage sequencing: normal flow, or the one cycle after a load-use bubble.
  typedef enum logic [0:0] {
    RUN,
    LU_STALL
  } id_ex_state_t;

  // Control bits carried from ID into EX.
  typedef struct packed {
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
    logic jump;
  } ex_ctrl_t;

  // A bubble must not write registers or memory, or redirect the PC.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. A store's data operand is excluded because it is forwarded later.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic                  valid_ex_i,
  input  logic                  memread_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_i,
  input  logic                  valid_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  memwrite_id_i,
  output logic                  hz_o
);

  logic rs1_match;
  logic rs2_match;

  // Source matches against the load destination; x0 never carries a dependency.
  always_comb begin
    rs1_match = (rs1_id_i == rd_ex_i);
    rs2_match = (rs2_id_i == rd_ex_i) & ~memwrite_id_i;
    hz_o      = valid_ex_i & memread_ex_i & (rd_ex_i != '0) & valid_id_i &
                (rs1_match | rs2_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush handling and
// saturating stall/flush event counters.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID_ID,
  input  logic [XLEN-1:0]  PC_ID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [4:0]       RD_ID,
  input  logic [XLEN-1:0]  RD1_ID,
  input  logic [XLEN-1:0]  RD2_ID,
  input  logic [XLEN-1:0]  IMM_ID,
  input  logic [3:0]       ALUCTRL_ID,
  input  logic             ALUSRC_ID,
  input  logic             REGWRITE_ID,
  input  logic             MEMREAD_ID,
  input  logic             MEMWRITE_ID,
  input  logic             MEMTOREG_ID,
  input  logic             BRANCH_ID,
  input  logic             JUMP_ID,
  input  logic             PCSRC_EX,
  input  logic             EXT_STALL,
  output logic [XLEN-1:0]  PC_EX,
  output logic [XLEN-1:0]  RD1_EX,
  output logic [XLEN-1:0]  RD2_EX,
  output logic [XLEN-1:0]  IMM_EX,
  output logic [4:0]       RS1_EX,
  output logic [4:0]       RS2_EX,
  output logic [4:0]       RD_EX,
  output logic [3:0]       ALUCTRL_EX,
  output logic             ALUSRC_EX,
  output logic             REGWRITE_EX,
  output logic             MEMREAD_EX,
  output logic             MEMWRITE_EX,
  output logic             MEMTOREG_EX,
  output logic             BRANCH_EX,
  output logic             JUMP_EX,
  output logic             VALID_EX,
  output logic             STALL,
  output logic             FLUSH_IFID,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  id_ex_state_t    state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      aluctrl_q, aluctrl_d;
  ex_ctrl_t        ctrl_q, ctrl_d;
  ex_ctrl_t        ctrl_id;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hz;
  logic lu_hz;

  hazard_detect u_hazard_detect (
    .valid_ex_i    (valid_q),
    .memread_ex_i  (ctrl_q.memread),
    .rd_ex_i       (rd_q),
    .valid_id_i    (VALID_ID),
    .rs1_id_i      (RS1_ID),
    .rs2_id_i      (RS2_ID),
    .memwrite_id_i (MEMWRITE_ID),
    .hz_o          (hz)
  );

  // Pack ID control and derive the combinational stall/flush requests.
  always_comb begin
    ctrl_id.alusrc   = ALUSRC_ID;
    ctrl_id.regwrite = REGWRITE_ID;
    ctrl_id.memread  = MEMREAD_ID;
    ctrl_id.memwrite = MEMWRITE_ID;
    ctrl_id.memtoreg = MEMTOREG_ID;
    ctrl_id.branch   = BRANCH_ID;
    ctrl_id.jump     = JUMP_ID;
    // The cycle after a bubble the hazard is masked: EX holds the bubble.
    lu_hz      = hz & (state_q == RUN);
    STALL      = RST_N & lu_hz & ~PCSRC_EX & ~EXT_STALL;
    FLUSH_IFID = PCSRC_EX & ~EXT_STALL;
  end

  // Next-state: flush beats load-use bubble, which beats a normal ID capture.
  always_comb begin
    state_d     = RUN;
    valid_d     = 1'b0;
    pc_d        = '0;
    rd1_d       = '0;
    rd2_d       = '0;
    imm_d       = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    aluctrl_d   = '0;
    ctrl_d      = EX_CTRL_BUBBLE;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PCSRC_EX) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, ~&flush_cnt_q};
    end else if (lu_hz) begin
      state_d     = LU_STALL;
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~&stall_cnt_q};
    end else begin
      valid_d   = VALID_ID;
      pc_d      = PC_ID;
      rd1_d     = RD1_ID;
      rd2_d     = RD2_ID;
      imm_d     = IMM_ID;
      rs1_d     = RS1_ID;
      rs2_d     = RS2_ID;
      rd_d      = RD_ID;
      aluctrl_d = ALUCTRL_ID;
      ctrl_d    = ctrl_id;
    end
  end

  // Stage registers: synchronous reset, frozen entirely while EXT_STALL is high.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= RUN;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      aluctrl_q   <= '0;
      ctrl_q      <= EX_CTRL_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!EXT_STALL) begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      aluctrl_q   <= aluctrl_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Drive registered outputs.
  always_comb begin
    VALID_EX    = valid_q;
    PC_EX       = pc_q;
    RD1_EX      = rd1_q;
    RD2_EX      = rd2_q;
    IMM_EX      = imm_q;
    RS1_EX      = rs1_q;
    RS2_EX      = rs2_q;
    RD_EX       = rd_q;
    ALUCTRL_EX  = aluctrl_q;
    ALUSRC_EX   = ctrl_q.alusrc;
    REGWRITE_EX = ctrl_q.regwrite;
    MEMREAD_EX  = ctrl_q.memread;
    MEMWRITE_EX = ctrl_q.memwrite;
    MEMTOREG_EX = ctrl_q.memtoreg;
    BRANCH_EX   = ctrl_q.branch;
    JUMP_EX     = ctrl_q.jump;
    STALL_CNT   = stall_cnt_q;
    FLUSH_CNT   = flush_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural stage model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        jump;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n, pcsrc, ext_stall;
  instr_t id;
  instr_t dut_ex;

  logic [31:0] pc_ex, rd1_ex, rd2_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [3:0]  aluctrl_ex;
  logic alusrc_ex, regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, branch_ex, jump_ex;
  logic valid_ex, stall, flush_ifid;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Behavioural model of the EX-side contents.
  instr_t m_ex;
  bit     m_after_bubble;
  int     m_scnt, m_fcnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .CLK (clk), .RST_N (rst_n), .VALID_ID (id.valid), .PC_ID (id.pc),
    .RS1_ID (id.rs1), .RS2_ID (id.rs2), .RD_ID (id.rd),
    .RD1_ID (id.rd1), .RD2_ID (id.rd2), .IMM_ID (id.imm), .ALUCTRL_ID (id.alu),
    .ALUSRC_ID (id.alusrc), .REGWRITE_ID (id.regwrite), .MEMREAD_ID (id.memread),
    .MEMWRITE_ID (id.memwrite), .MEMTOREG_ID (id.memtoreg), .BRANCH_ID (id.branch),
    .JUMP_ID (id.jump), .PCSRC_EX (pcsrc), .EXT_STALL (ext_stall),
    .PC_EX (pc_ex), .RD1_EX (rd1_ex), .RD2_EX (rd2_ex), .IMM_EX (imm_ex),
    .RS1_EX (rs1_ex), .RS2_EX (rs2_ex), .RD_EX (rd_ex), .ALUCTRL_EX (aluctrl_ex),
    .ALUSRC_EX (alusrc_ex), .REGWRITE_EX (regwrite_ex), .MEMREAD_EX (memread_ex),
    .MEMWRITE_EX (memwrite_ex), .MEMTOREG_EX (memtoreg_ex), .BRANCH_EX (branch_ex),
    .JUMP_EX (jump_ex), .VALID_EX (valid_ex), .STALL (stall), .FLUSH_IFID (flush_ifid),
    .STALL_CNT (stall_cnt), .FLUSH_CNT (flush_cnt)
  );

  assign dut_ex = {valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rd1_ex, rd2_ex, imm_ex,
                   aluctrl_ex, alusrc_ex, regwrite_ex, memread_ex, memwrite_ex,
                   memtoreg_ex, branch_ex, jump_ex};

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A load in EX whose destination the ID instruction reads (store data excluded).
  function automatic bit model_dep();
    return m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id.valid &&
           ((id.rs1 == m_ex.rd) || ((id.rs2 == m_ex.rd) && !id.memwrite));
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk) begin
    bit dep;
    dep = model_dep();
    if (!rst_n) begin
      m_ex <= '0; m_after_bubble <= 1'b0; m_scnt <= 0; m_fcnt <= 0;
    end else if (!ext_stall) begin
      if (pcsrc) begin
        m_ex <= '0; m_after_bubble <= 1'b0; m_fcnt <= sat16(m_fcnt);
      end else if (dep && !m_after_bubble) begin
        m_ex <= '0; m_after_bubble <= 1'b1; m_scnt <= sat16(m_scnt);
      end else begin
        m_ex <= id; m_after_bubble <= 1'b0;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (checking) begin
      chk("stall", stall, rst_n && model_dep() && !m_after_bubble && !pcsrc && !ext_stall);
      chk("flush_ifid", flush_ifid, pcsrc && !ext_stall);
      chk("ex_regs", dut_ex, m_ex);
      chk("stall_cnt", stall_cnt, m_scnt[15:0]);
      chk("flush_cnt", flush_cnt, m_fcnt[15:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk_load(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t t = '0;
    t.valid = 1; t.pc = 32'h100; t.rs1 = rs1; t.rd = rd; t.imm = 32'h4; t.alusrc = 1;
    t.regwrite = 1; t.memread = 1; t.memtoreg = 1;
    return t;
  endfunction

  function automatic instr_t mk_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    instr_t t = '0;
    t.valid = 1; t.pc = 32'h104; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.regwrite = 1;
    t.rd1 = 32'h11; t.rd2 = 32'h22; t.alu = 4'h2;
    return t;
  endfunction

  function automatic instr_t mk_store(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = '0;
    t.valid = 1; t.pc = 32'h108; t.rs1 = rs1; t.rs2 = rs2; t.alusrc = 1; t.memwrite = 1;
    return t;
  endfunction

  initial begin
    rst_n = 0; pcsrc = 0; ext_stall = 0; id = '0;
    tick();
    checking = 1'b1;
    chk("reset_ex", dut_ex, 160'h0);
    rst_n = 1;

    // lw x5 ; add x6,x5,x7 -> one bubble, then the add
    id = mk_load(5, 8); tick();
    id = mk_alu(6, 5, 7); #1 chk("lu_stall", stall, 1);
    tick(); #1 chk("lu_bubble_valid", valid_ex, 0); chk("lu_bubble_rd", rd_ex, 0);
    chk("lu_masked", stall, 0);
    tick(); #1 chk("lu_add_rd", rd_ex, 6); chk("lu_add_valid", valid_ex, 1);
    chk("lu_stall_cnt", stall_cnt, 1);

    // lw x5 ; sw x5,0(x8) -> no stall
    id = mk_load(5, 8); tick();
    id = mk_store(8, 5); #1 chk("st_nostall", stall, 0);
    tick(); #1 chk("st_in_ex", memwrite_ex, 1); chk("st_stall_cnt", stall_cnt, 1);

    // lw x0 ; add x1,x0,x0 -> no stall
    id = mk_load(0, 8); tick();
    id = mk_alu(1, 0, 0); #1 chk("x0_nostall", stall, 0);
    tick(); #1 chk("x0_add_rd", rd_ex, 1);

    // flush together with a load-use hazard
    rst_n = 0; id = '0; tick(); #1 chk("rst_scnt", stall_cnt, 0);
    rst_n = 1;
    id = mk_load(5, 8); tick();
    id = mk_alu(6, 5, 7); pcsrc = 1; #1 chk("fl_flush", flush_ifid, 1);
    chk("fl_nostall", stall, 0);
    tick(); pcsrc = 0; id = '0; #1 chk("fl_bubble", valid_ex, 0);
    chk("fl_fcnt", flush_cnt, 1); chk("fl_scnt", stall_cnt, 0);

    // EXT_STALL for 3 cycles over a pending hazard
    id = mk_load(5, 8); tick();
    id = mk_alu(6, 5, 7); ext_stall = 1; #1 chk("es_nostall", stall, 0);
    repeat (3) begin
      tick(); #1 chk("es_frozen_rd", rd_ex, 5); chk("es_frozen_cnt", stall_cnt, 0);
    end
    ext_stall = 0; #1 chk("es_release_stall", stall, 1);
    tick(); #1 chk("es_bubble", valid_ex, 0); chk("es_scnt", stall_cnt, 1);
    tick(); #1 chk("es_add_rd", rd_ex, 6); chk("es_scnt_once", stall_cnt, 1);

    // reset while in LU_STALL
    id = mk_load(5, 8); tick();
    id = mk_alu(6, 5, 7); tick();
    rst_n = 0; #1 chk("rst_stall_low", stall, 0);
    tick(); #1 chk("rst_ex_zero", dut_ex, 160'h0); chk("rst_fcnt", flush_cnt, 0);
    rst_n = 1;
    id = mk_load(5, 8); tick();
    id = mk_alu(6, 5, 7); #1 chk("rst_run_again", stall, 1);

    // randomized traffic
    repeat (3000) begin
      id.valid = ($urandom_range(3) != 0);
      id.pc = $urandom; id.rd1 = $urandom; id.rd2 = $urandom; id.imm = $urandom;
      id.rs1 = 5'($urandom_range(3)); id.rs2 = 5'($urandom_range(3));
      id.rd = 5'($urandom_range(3)); id.alu = 4'($urandom);
      id.memread = $urandom_range(1);
      id.memwrite = !id.memread && ($urandom_range(1) == 1);
      id.alusrc = $urandom_range(1); id.regwrite = $urandom_range(1);
      id.memtoreg = $urandom_range(1); id.branch = $urandom_range(1);
      id.jump = $urandom_range(1);
      pcsrc = ($urandom_range(7) == 0);
      ext_stall = ($urandom_range(5) == 0);
      rst_n = ($urandom_range(63) != 0);
      tick();
    end

    // flush counter saturation
    rst_n = 0; pcsrc = 0; ext_stall = 0; tick();
    rst_n = 1; pcsrc = 1;
    repeat (65540) tick();
    chk("fcnt_saturated", flush_cnt, 16'hFFFF);
    pcsrc = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
